mem_ctrl: RTL and testbench

Single-port byte-serial memory controller between the pipeline's instruction-fetch and MEM stages and the 8-bit RAM/IO bus. It arbitrates fetch and data traffic, serialises 32-bit loads and 1/2/4-byte stores into per-byte RAM cycles, and returns a one-cycle `done` pulse. It also drives the 2-bit `busy` status that the MEM stage uses to decide whether to issue a request.

---
 rtl/mem_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller between the fetch/MEM stages and an
// 8-bit RAM/IO bus with one-cycle read latency. Serialises 32-bit loads and
// 1/2/4-byte stores, arbitrates store > load > fetch, and lets MEM traffic
// preempt an in-flight fetch.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    output logic        if_done_out,
    output logic [31:0] inst_out,
    input  logic        read_req_in,
    input  logic        write_req_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_val_in,
    input  logic [2:0]  store_len_in,
    output logic        mem_done_out,
    output logic [31:0] mem_val_read_out,
    output logic [1:0]  memctrl_busy_out,
    input  logic [7:0]  mem_din_in,
    output logic [7:0]  mem_dout_out,
    output logic [31:0] mem_a_out,
    output logic        mem_wr_out
);

    typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  len_q, len_d;
    logic [23:0] asm_q, asm_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] mem_val_q, mem_val_d;
    logic        if_done_q, if_done_d;
    logic        mem_done_q, mem_done_d;

    logic        start_valid;
    state_t      start_state;
    logic [31:0] start_addr;
    logic        mem_req;
    logic        read_step;
    logic        last_wr;

    assign mem_req = write_req_in | read_req_in;
    assign last_wr = (cnt_q == len_q) || (cnt_q == 3'd3);

    // Pick the request that would be taken this cycle: store, then load, then fetch.
    always_comb begin
        start_valid = 1'b0;
        start_state = IDLE;
        start_addr  = 32'd0;
        if (write_req_in) begin
            start_valid = 1'b1;
            start_state = MEM_WR;
            start_addr  = mem_addr_in;
        end else if (read_req_in) begin
            start_valid = 1'b1;
            start_state = MEM_RD;
            start_addr  = mem_addr_in;
        end else if (if_req_in) begin
            start_valid = 1'b1;
            start_state = IF_RD;
            start_addr  = if_addr_in;
        end
    end

    // Next-state logic: accept requests, step the byte counter, assemble read words.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        len_d      = len_q;
        asm_d      = asm_q;
        inst_d     = inst_q;
        mem_val_d  = mem_val_q;
        if_done_d  = 1'b0;
        mem_done_d = 1'b0;
        read_step  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start_valid) begin
                    state_d = start_state;
                    addr_d  = start_addr;
                    data_d  = mem_val_in;
                    len_d   = store_len_in;
                    cnt_d   = 3'd0;
                end
            end
            IF_RD: begin
                if (mem_req) begin
                    state_d = start_state;
                    addr_d  = start_addr;
                    data_d  = mem_val_in;
                    len_d   = store_len_in;
                    cnt_d   = 3'd0;
                end else if (!if_req_in) begin
                    state_d = IDLE;
                end else begin
                    read_step = 1'b1;
                end
            end
            MEM_RD: read_step = 1'b1;
            MEM_WR: begin
                if (last_wr) begin
                    state_d    = DONE;
                    mem_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (read_step) begin
            case (cnt_q)
                3'd1:    asm_d[7:0]   = mem_din_in;
                3'd2:    asm_d[15:8]  = mem_din_in;
                3'd3:    asm_d[23:16] = mem_din_in;
                default: asm_d = asm_q;
            endcase
            if (cnt_q == 3'd4) begin
                state_d = DONE;
                if (state_q == IF_RD) begin
                    inst_d    = {mem_din_in, asm_q};
                    if_done_d = 1'b1;
                end else begin
                    mem_val_d  = {mem_din_in, asm_q};
                    mem_done_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            len_q      <= 3'd0;
            asm_q      <= 24'd0;
            inst_q     <= 32'd0;
            mem_val_q  <= 32'd0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            len_q      <= len_d;
            asm_q      <= asm_d;
            inst_q     <= inst_d;
            mem_val_q  <= mem_val_d;
            if_done_q  <= if_done_d;
            mem_done_q <= mem_done_d;
        end
    end

    // Bus drive: address/data only during active byte cycles, zero otherwise.
    always_comb begin
        mem_a_out        = 32'd0;
        mem_wr_out       = 1'b0;
        mem_dout_out     = 8'd0;
        memctrl_busy_out = 2'b00;
        case (state_q)
            IF_RD, MEM_RD: begin
                memctrl_busy_out = (state_q == IF_RD) ? 2'b01 : 2'b10;
                if (cnt_q <= 3'd3) begin
                    mem_a_out = addr_q + {29'd0, cnt_q};
                end
            end
            MEM_WR: begin
                memctrl_busy_out = 2'b10;
                mem_wr_out       = 1'b1;
                mem_a_out        = addr_q + {29'd0, cnt_q};
                case (cnt_q[1:0])
                    2'd0:    mem_dout_out = data_q[7:0];
                    2'd1:    mem_dout_out = data_q[15:8];
                    2'd2:    mem_dout_out = data_q[23:16];
                    default: mem_dout_out = data_q[31:24];
                endcase
            end
            default: ;
        endcase
    end

    assign if_done_out      = if_done_q;
    assign mem_done_out     = mem_done_q;
    assign inst_out         = inst_q;
    assign mem_val_read_out = mem_val_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a 1-cycle-latency RAM model.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        if_req_in;
    logic [31:0] if_addr_in;
    logic        if_done_out;
    logic [31:0] inst_out;
    logic        read_req_in;
    logic        write_req_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_val_in;
    logic [2:0]  store_len_in;
    logic        mem_done_out;
    logic [31:0] mem_val_read_out;
    logic [1:0]  memctrl_busy_out;
    logic [7:0]  mem_din_in;
    logic [7:0]  mem_dout_out;
    logic [31:0] mem_a_out;
    logic        mem_wr_out;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  ram [0:1023];
    logic [44:0] obs;
    logic [44:0] exp_v;

    mem_ctrl dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .if_req_in        (if_req_in),
        .if_addr_in       (if_addr_in),
        .if_done_out      (if_done_out),
        .inst_out         (inst_out),
        .read_req_in      (read_req_in),
        .write_req_in     (write_req_in),
        .mem_addr_in      (mem_addr_in),
        .mem_val_in       (mem_val_in),
        .store_len_in     (store_len_in),
        .mem_done_out     (mem_done_out),
        .mem_val_read_out (mem_val_read_out),
        .memctrl_busy_out (memctrl_busy_out),
        .mem_din_in       (mem_din_in),
        .mem_dout_out     (mem_dout_out),
        .mem_a_out        (mem_a_out),
        .mem_wr_out       (mem_wr_out)
    );

    always #5 clk_in = ~clk_in;

    // RAM read port: byte for the address of cycle t appears in cycle t+1.
    always @(posedge clk_in) begin
        mem_din_in <= ram[mem_a_out[9:0]];
    end

    assign obs = {memctrl_busy_out, mem_wr_out, if_done_out, mem_done_out, mem_a_out, mem_dout_out};

    function automatic logic [44:0] vec(input logic [1:0] busy, input logic wr, input logic ifd,
                                        input logic md, input logic [31:0] a, input logic [7:0] d);
        return {busy, wr, ifd, md, a, d};
    endfunction

    task automatic put_word(input int base, input logic [31:0] w);
        for (int k = 0; k < 4; k++) ram[base + k] = w[8*k +: 8];
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        if_req_in = 1'b0; if_addr_in = 32'd0;
        read_req_in = 1'b0; write_req_in = 1'b0;
        mem_addr_in = 32'd0; mem_val_in = 32'd0; store_len_in = 3'd0;
        repeat (2) @(negedge clk_in);
        checks++;
        if (obs !== 45'd0) begin
            failures++;
            $display("[TB] FAIL reset_bus: got %h want %h", obs, 45'd0);
        end
        checks++;
        if ({inst_out, mem_val_read_out} !== 64'd0) begin
            failures++;
            $display("[TB] FAIL reset_words: got %h want 0", {inst_out, mem_val_read_out});
        end
        @(posedge clk_in); #1;
        rst_in = 1'b1;
    endtask

    task automatic test_load_word();
        for (int c = 0; c <= 6; c++) begin
            @(posedge clk_in); #1;
            if (c == 0) begin read_req_in = 1'b1; mem_addr_in = 32'h100; end
            if (c == 1) read_req_in = 1'b0;
            @(negedge clk_in);
            exp_v = vec((c >= 1 && c <= 5) ? 2'b10 : 2'b00, 1'b0, 1'b0, (c == 6),
                        (c >= 1 && c <= 4) ? 32'h100 + c - 1 : 32'd0, 8'd0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("[TB] FAIL load c%0d: got %h want %h", c, obs, exp_v);
            end
        end
        checks++;
        if (mem_val_read_out !== 32'h12345678) begin
            failures++;
            $display("[TB] FAIL load_word: got %h want 12345678", mem_val_read_out);
        end
    endtask

    task automatic test_stores();
        logic [2:0]  lens [3];
        logic [31:0] val;
        int n;
        lens[0] = 3'd0; lens[1] = 3'd1; lens[2] = 3'd3;
        val = 32'hAABBCCDD;
        for (int t = 0; t < 3; t++) begin
            n = int'(lens[t]) + 1;
            for (int c = 0; c <= n + 2; c++) begin
                @(posedge clk_in); #1;
                if (c == 0) begin
                    write_req_in = 1'b1; mem_addr_in = 32'h200;
                    mem_val_in = val; store_len_in = lens[t];
                end
                if (c == 1) write_req_in = 1'b0;
                @(negedge clk_in);
                if (c >= 1 && c <= n)
                    exp_v = vec(2'b10, 1'b1, 1'b0, 1'b0, 32'h200 + c - 1, val[8*(c-1) +: 8]);
                else
                    exp_v = vec(2'b00, 1'b0, 1'b0, (c == n + 1), 32'd0, 8'd0);
                checks++;
                if (obs !== exp_v) begin
                    failures++;
                    $display("[TB] FAIL store_len%0d c%0d: got %h want %h", lens[t], c, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_arbitration();
        for (int c = 0; c <= 13; c++) begin
            @(posedge clk_in); #1;
            if (c == 0) begin
                if_req_in = 1'b1; if_addr_in = 32'h0;
                read_req_in = 1'b1; mem_addr_in = 32'h100;
            end
            if (c == 1) read_req_in = 1'b0;
            if (c == 12) if_req_in = 1'b0;
            @(negedge clk_in);
            if (c >= 1 && c <= 4)       exp_v = vec(2'b10, 0, 0, 0, 32'h100 + c - 1, 8'd0);
            else if (c == 5)            exp_v = vec(2'b10, 0, 0, 0, 32'd0, 8'd0);
            else if (c == 6)            exp_v = vec(2'b00, 0, 0, 1, 32'd0, 8'd0);
            else if (c >= 7 && c <= 10) exp_v = vec(2'b01, 0, 0, 0, c - 7, 8'd0);
            else if (c == 11)           exp_v = vec(2'b01, 0, 0, 0, 32'd0, 8'd0);
            else if (c == 12)           exp_v = vec(2'b00, 0, 1, 0, 32'd0, 8'd0);
            else                        exp_v = vec(2'b00, 0, 0, 0, 32'd0, 8'd0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("[TB] FAIL arb c%0d: got %h want %h", c, obs, exp_v);
            end
            if (c == 6) begin
                checks++;
                if (mem_val_read_out !== 32'h12345678) begin
                    failures++;
                    $display("[TB] FAIL arb_load: got %h want 12345678", mem_val_read_out);
                end
            end
            if (c == 12) begin
                checks++;
                if (inst_out !== 32'h00500513) begin
                    failures++;
                    $display("[TB] FAIL arb_inst: got %h want 00500513", inst_out);
                end
            end
        end
    endtask

    task automatic test_preemption();
        logic [31:0] val;
        val = 32'h11223344;
        put_word(0, 32'hDEADBEEF);
        for (int c = 0; c <= 14; c++) begin
            @(posedge clk_in); #1;
            if (c == 0) begin if_req_in = 1'b1; if_addr_in = 32'h0; end
            if (c == 2) begin
                write_req_in = 1'b1; mem_addr_in = 32'h204;
                mem_val_in = val; store_len_in = 3'd3;
            end
            if (c == 3) write_req_in = 1'b0;
            if (c == 13) if_req_in = 1'b0;
            @(negedge clk_in);
            if (c == 0)                  exp_v = vec(2'b00, 0, 0, 0, 32'd0, 8'd0);
            else if (c <= 2)             exp_v = vec(2'b01, 0, 0, 0, c - 1, 8'd0);
            else if (c <= 6)             exp_v = vec(2'b10, 1, 0, 0, 32'h204 + c - 3, val[8*(c-3) +: 8]);
            else if (c == 7)             exp_v = vec(2'b00, 0, 0, 1, 32'd0, 8'd0);
            else if (c <= 11)            exp_v = vec(2'b01, 0, 0, 0, c - 8, 8'd0);
            else if (c == 12)            exp_v = vec(2'b01, 0, 0, 0, 32'd0, 8'd0);
            else if (c == 13)            exp_v = vec(2'b00, 0, 1, 0, 32'd0, 8'd0);
            else                         exp_v = vec(2'b00, 0, 0, 0, 32'd0, 8'd0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("[TB] FAIL preempt c%0d: got %h want %h", c, obs, exp_v);
            end
            if (c == 13) begin
                checks++;
                if (inst_out !== 32'hDEADBEEF) begin
                    failures++;
                    $display("[TB] FAIL preempt_inst: got %h want deadbeef", inst_out);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c <= 13; c++) begin
            @(posedge clk_in); #1;
            if (c == 0) begin read_req_in = 1'b1; mem_addr_in = 32'h104; end
            if (c == 1) read_req_in = 1'b0;
            if (c == 6) begin read_req_in = 1'b1; mem_addr_in = 32'h100; end
            if (c == 7) read_req_in = 1'b0;
            @(negedge clk_in);
            if (c >= 1 && c <= 4)        exp_v = vec(2'b10, 0, 0, 0, 32'h104 + c - 1, 8'd0);
            else if (c >= 7 && c <= 10)  exp_v = vec(2'b10, 0, 0, 0, 32'h100 + c - 7, 8'd0);
            else if (c == 5 || c == 11)  exp_v = vec(2'b10, 0, 0, 0, 32'd0, 8'd0);
            else if (c == 6 || c == 12)  exp_v = vec(2'b00, 0, 0, 1, 32'd0, 8'd0);
            else                         exp_v = vec(2'b00, 0, 0, 0, 32'd0, 8'd0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("[TB] FAIL b2b c%0d: got %h want %h", c, obs, exp_v);
            end
            if (c == 6) begin
                checks++;
                if (mem_val_read_out !== 32'hCAFEF00D) begin
                    failures++;
                    $display("[TB] FAIL b2b_first: got %h want cafef00d", mem_val_read_out);
                end
            end
            if (c == 12) begin
                checks++;
                if (mem_val_read_out !== 32'h12345678) begin
                    failures++;
                    $display("[TB] FAIL b2b_second: got %h want 12345678", mem_val_read_out);
                end
            end
        end
    endtask

    task automatic test_reset_mid_store();
        for (int c = 0; c <= 2; c++) begin
            @(posedge clk_in); #1;
            if (c == 0) begin
                write_req_in = 1'b1; mem_addr_in = 32'h200;
                mem_val_in = 32'h55667788; store_len_in = 3'd3;
            end
            if (c == 1) write_req_in = 1'b0;
            @(negedge clk_in);
        end
        checks++;
        exp_v = vec(2'b10, 1, 0, 0, 32'h201, 8'h77);
        if (obs !== exp_v) begin
            failures++;
            $display("[TB] FAIL rst_pre: got %h want %h", obs, exp_v);
        end
        rst_in = 1'b0;
        #1;
        checks++;
        if (obs !== 45'd0) begin
            failures++;
            $display("[TB] FAIL rst_async_bus: got %h want 0", obs);
        end
        checks++;
        if ({inst_out, mem_val_read_out} !== 64'd0) begin
            failures++;
            $display("[TB] FAIL rst_async_words: got %h want 0", {inst_out, mem_val_read_out});
        end
        for (int c = 3; c <= 6; c++) begin
            @(posedge clk_in); #1;
            if (c == 4) rst_in = 1'b1;
            @(negedge clk_in);
            checks++;
            if (obs !== 45'd0) begin
                failures++;
                $display("[TB] FAIL rst_after c%0d: got %h want 0", c, obs);
            end
        end
        test_load_word();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        put_word(32'h000, 32'h00500513);
        put_word(32'h100, 32'h12345678);
        put_word(32'h104, 32'hCAFEF00D);

        test_reset();
        test_load_word();
        test_stores();
        test_arbitration();
        test_preemption();
        test_back_to_back();
        test_reset_mid_store();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
